// File: rtl/up_down_cmd_if.sv
// Button/command bundle between the up/down command controller and its environment.
// o_en is a single-cycle strobe with no ready/backpressure; the counter consumes it on the next edge.
interface up_down_cmd_if;
  logic       i_btn_up;
  logic       i_btn_down;
  logic       i_hold;
  logic       o_en;
  logic       o_up_down;
  logic       o_busy;
  logic [1:0] dbg_state;

  modport master (
    output i_btn_up, i_btn_down, i_hold,
    input  o_en, o_up_down, o_busy, dbg_state
  );

  modport slave (
    input  i_btn_up, i_btn_down, i_hold,
    output o_en, o_up_down, o_busy, dbg_state
  );
endinterface

// File: rtl/up_down_cmd_ctrl.sv
// Debounced up/down push-button front end issuing one-cycle count-enable pulses.
// Optional auto-repeat while a button is held: define UP_DOWN_CMD_AUTO_REPEAT_EN.
module up_down_cmd_ctrl #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned REPEAT_CYCLES = 16
) (
  input logic          i_clk,
  input logic          i_rst,
  up_down_cmd_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || DB_CYCLES > 255 || REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
    $error("up_down_cmd_ctrl: parameter out of range");
  end

  // Index 0 is the up button, index 1 the down button throughout.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] lvl;
  logic [1:0] lvl_d;
  logic [7:0] db_cnt [2];
  logic [1:0] press;

  assign raw   = {bus.i_btn_down, bus.i_btn_up};
  assign press = lvl & ~lvl_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          lvl[i]    <= ~lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  state_t state;
  state_t state_n;
  logic   load_dir;
  logic   dir;
  logic   rep_hit;

`ifdef UP_DOWN_CMD_AUTO_REPEAT_EN
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rep_cnt;
  logic        rep_run;

  // Counts only while exactly one button stays held in HOLD and downstream is not holding us off.
  assign rep_run = (state == HOLD) && (lvl == 2'b01 || lvl == 2'b10) && !bus.i_hold;
  assign rep_hit = rep_run && (rep_cnt == REP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || !rep_run || rep_hit) rep_cnt <= '0;
    else                              rep_cnt <= rep_cnt + 16'd1;
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    load_dir = 1'b0;
    case (state)
      IDLE: begin
        // Simultaneous presses are ambiguous and dropped, as are presses under hold.
        if (!bus.i_hold && (press == 2'b01 || press == 2'b10)) begin
          state_n  = ISSUE;
          load_dir = 1'b1;
        end
      end
      ISSUE: state_n = HOLD;
      HOLD: begin
        if (lvl == 2'b00) state_n = IDLE;
        else if (rep_hit) state_n = ISSUE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      dir   <= 1'b0;
    end else begin
      state <= state_n;
      if (load_dir) dir <= press[0];
    end
  end

  assign bus.o_en      = (state == ISSUE);
  assign bus.o_busy    = (state != IDLE);
  assign bus.o_up_down = dir;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_up_down_cmd_ctrl.sv
// Bench for up_down_cmd_ctrl: directed vector table, corner sequences and random stimulus
// checked every cycle against a window-based behavioural model.
module tb_up_down_cmd_ctrl;
  localparam int DB  = 4;
  localparam int REP = 16;
`ifdef UP_DOWN_CMD_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int REP_EXTRA = AUTO ? 3 : 0;

  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_HOLD  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  up_down_cmd_if bus ();

  up_down_cmd_ctrl #(.DB_CYCLES(DB), .REPEAT_CYCLES(REP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         pulse_cnt = 0;
  int         busy_any = 0;
  logic [0:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [1:0] raw_q[$];
  logic [1:0] fed_q[$];
  logic [1:0] m_lvl;
  logic [1:0] m_lvl_prev;
  int         m_mode;
  logic       m_dir;
  int         m_rep;

  task automatic model_reset();
    raw_q.delete();
    raw_q.push_back(2'b00);
    raw_q.push_back(2'b00);
    fed_q.delete();
    exp_q.delete();
    m_lvl      = 2'b00;
    m_lvl_prev = 2'b00;
    m_mode     = M_IDLE;
    m_dir      = 1'b0;
    m_rep      = 0;
  endtask

  task automatic model_edge(input logic up, input logic dn, input logic hd, input logic r);
    logic [1:0] rise;
    logic [1:0] fed;
    logic [1:0] nlvl;
    bit         rep_cond;
    bit         all_diff;
    if (r) begin
      model_reset();
      return;
    end
    rise     = m_lvl & ~m_lvl_prev;
    rep_cond = AUTO && (m_mode == M_HOLD) && ($countones(m_lvl) == 1) && !hd;
    if (!rep_cond) m_rep = 0;
    case (m_mode)
      M_IDLE: begin
        if (!hd && $countones(rise) == 1) begin
          m_mode = M_ISSUE;
          m_dir  = rise[0];
          exp_q.push_back(m_dir);
        end
      end
      M_ISSUE: m_mode = M_HOLD;
      default: begin
        if (m_lvl == 2'b00) begin
          m_mode = M_IDLE;
        end else if (rep_cond) begin
          m_rep++;
          if (m_rep == REP) begin
            m_rep  = 0;
            m_mode = M_ISSUE;
            exp_q.push_back(m_dir);
          end
        end
      end
    endcase
    // A raw sample reaches the debouncer two edges after it is taken.
    raw_q.push_back({dn, up});
    fed = raw_q.pop_front();
    fed_q.push_back(fed);
    if (fed_q.size() > DB) void'(fed_q.pop_front());
    nlvl = m_lvl;
    for (int b = 0; b < 2; b++) begin
      all_diff = (fed_q.size() == DB);
      foreach (fed_q[j]) if (fed_q[j][b] == m_lvl[b]) all_diff = 1'b0;
      if (all_diff) nlvl[b] = ~m_lvl[b];
    end
    m_lvl_prev = m_lvl;
    m_lvl      = nlvl;
  endtask

  // ---------------- comparison helpers ----------------
  task automatic cmp_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [0:0] d;
    cmp_bit("en", bus.o_en, m_mode == M_ISSUE);
    cmp_bit("busy", bus.o_busy, m_mode != M_IDLE);
    cmp_bit("up_down", bus.o_up_down, m_dir);
    if (bus.o_en === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pulse_dir: got unexpected pulse expected none at %0t", $time);
      end else begin
        d = exp_q.pop_front();
        cmp_bit("pulse_dir", bus.o_up_down, d[0]);
      end
    end
    if (bus.o_busy === 1'b1) busy_any++;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic up, input logic dn, input logic hd, input logic r);
    @(negedge clk);
    bus.i_btn_up   = up;
    bus.i_btn_down = dn;
    bus.i_hold     = hd;
    rst            = r;
    @(posedge clk);
    model_edge(up, dn, hd, r);
    #1;
    check_cycle();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    logic  up;
    logic  dn;
    logic  hold;
    int    cycles;
    int    exp_pulses;
    logic  exp_dir;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int first_at;

    vecs[0] = '{"up15",       1'b1, 1'b0, 1'b0, 15, 1,             1'b1};
    vecs[1] = '{"dn15",       1'b0, 1'b1, 1'b0, 15, 1,             1'b0};
    vecs[2] = '{"up_glitch3", 1'b1, 1'b0, 1'b0, 3,  0,             1'b0};
    vecs[3] = '{"dn_glitch1", 1'b0, 1'b1, 1'b0, 1,  0,             1'b0};
    vecs[4] = '{"up_min4",    1'b1, 1'b0, 1'b0, 4,  1,             1'b1};
    vecs[5] = '{"dn_hold",    1'b0, 1'b1, 1'b1, 15, 0,             1'b0};
    vecs[6] = '{"up_long60",  1'b1, 1'b0, 1'b0, 60, 1 + REP_EXTRA, 1'b1};

    rst            = 1'b1;
    bus.i_btn_up   = 1'b0;
    bus.i_btn_down = 1'b0;
    bus.i_hold     = 1'b0;
    model_reset();

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cmp_bit("rst_en", bus.o_en, 1'b0);
    cmp_bit("rst_up_down", bus.o_up_down, 1'b0);
    cmp_bit("rst_busy", bus.o_busy, 1'b0);

    // Clean up press: exact latency and release timing
    pulse_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (k >= 6 && k <= 8) cmp_bit($sformatf("lat_en_k%0d", k), bus.o_en, k == 7);
      if (k == 7) cmp_bit("lat_dir", bus.o_up_down, 1'b1);
    end
    for (int k = 21; k <= 27; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 26) cmp_bit("rel_busy_26", bus.o_busy, 1'b1);
      if (k == 27) cmp_bit("rel_busy_27", bus.o_busy, 1'b0);
    end
    cmp_int("lat_pulses", pulse_cnt, AUTO ? 2 : 1);
    idle_steps(5);

    // Table-driven vectors, each from reset
    foreach (vecs[i]) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      pulse_cnt = 0;
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].up, vecs[i].dn, vecs[i].hold, 1'b0);
      idle_steps(20);
      cmp_int({vecs[i].name, "_pulses"}, pulse_cnt, vecs[i].exp_pulses);
      cmp_bit({vecs[i].name, "_dir"}, bus.o_up_down, vecs[i].exp_dir);
    end

    // Bouncing down button, then stable
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_cnt = 0;
    for (int k = 0; k < 12; k++) step(1'b0, ((k / 2) % 2) == 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    cmp_int("bounce_no_pulse", pulse_cnt, 0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle_steps(15);
    cmp_int("bounce_pulses", pulse_cnt, 1);
    cmp_bit("bounce_dir", bus.o_up_down, 1'b0);

    // Both buttons on the same edge
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_cnt = 0;
    busy_any  = 0;
    for (int k = 0; k < 30; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle_steps(10);
    cmp_int("both_pulses", pulse_cnt, 0);
    cmp_int("both_busy", busy_any, 0);

    // Press under hold is dropped; a fresh press afterwards works
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_cnt = 0;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(15);
    cmp_int("hold_dropped", pulse_cnt, 0);
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(15);
    cmp_int("hold_second_press", pulse_cnt, 1);

    // Reset while in HOLD with the button still held
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    cmp_bit("pre_rst_busy", bus.o_busy, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    cmp_bit("hold_rst_en", bus.o_en, 1'b0);
    cmp_bit("hold_rst_up_down", bus.o_up_down, 1'b0);
    cmp_bit("hold_rst_busy", bus.o_busy, 1'b0);
    pulse_cnt = 0;
    first_at  = -1;
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (bus.o_en === 1'b1 && first_at < 0) first_at = k;
    end
    idle_steps(15);
    cmp_int("post_rst_first", first_at, DB + 3);
    cmp_int("post_rst_pulses", pulse_cnt, 1);

    // Random stimulus against the model
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, 1'b1);
      end else begin
        int   len;
        logic [1:0] lv;
        logic hd;
        lv  = 2'($urandom_range(0, 3));
        hd  = ($urandom_range(0, 3) == 0);
        len = $urandom_range(1, 25);
        for (int c = 0; c < len; c++) step(lv[0], lv[1], hd, 1'b0);
      end
    end
    idle_steps(30);
    cmp_int("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
